// File: rtl/serial_crc_eq2.sv
// ---------------------------------------------------------------------------
// serial_crc_eq2
// Bit-serial CRC generator. It captures a DATA_W-bit message word and divides
// it, MSB first, one bit per clock, by G(x) = x^CRC_W + POLY. The LFSR is in
// augmented (long-division) form, so CRC_W zero bits are shifted in after the
// message. The remainder is published on data_out. The block runs
// continuously: LOAD -> SHIFT (DATA_W+CRC_W clocks) -> DONE -> LOAD.
//
// Ports
//   clk      in   1       rising-edge clock
//   reset    in   1       asynchronous, active-high; clears all state
//   data_in  in   DATA_W  message word, sampled only in LOAD
//   data_out out  CRC_W   registered remainder of the last completed message
// ---------------------------------------------------------------------------
module serial_crc_eq2 #(
  parameter int                 DATA_W = 6,
  parameter int                 CRC_W  = 5,
  parameter logic [CRC_W-1:0]   POLY   = 5'b00101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  output logic [CRC_W-1:0]  data_out
);

  localparam int CNT_W = $clog2(DATA_W + CRC_W);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MSG_END = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DATA_W + CRC_W - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_msg;
  logic [CRC_W-1:0]  r_lfsr;
  logic [CRC_W-1:0]  r_data_out;
  logic              w_bit;

  // One long-division step: shift in the next dividend bit and subtract
  // (XOR) the generator whenever the bit leaving the top is set.
  function automatic logic [CRC_W-1:0] lfsr_step(
    input logic [CRC_W-1:0] s,
    input logic             b
  );
    lfsr_step = {s[CRC_W-2:0], b} ^ (s[CRC_W-1] ? POLY : '0);
  endfunction

  // Message bits first, then the augmenting zeros.
  assign w_bit = (r_cnt < CNT_MSG_END) ? r_msg[DATA_W-1] : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_LOAD;
      r_cnt      <= '0;
      r_msg      <= '0;
      r_lfsr     <= '0;
      r_data_out <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_msg   <= data_in;
          r_lfsr  <= '0;
          r_cnt   <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_msg  <= {r_msg[DATA_W-2:0], 1'b0};
          r_lfsr <= lfsr_step(r_lfsr, w_bit);
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_data_out <= r_lfsr;
          r_state    <= ST_LOAD;
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_serial_crc_eq2.sv
module tb_serial_crc_eq2;

  localparam int DATA_W = 6;
  localparam int CRC_W  = 5;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic [CRC_W-1:0]  data_out;

  serial_crc_eq2 #(.DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(5'b00101)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] din;
    logic [CRC_W-1:0]  exp;
  } vec_t;

  vec_t              vecs[6];
  logic [CRC_W-1:0]  exp_q[$];
  logic [CRC_W-1:0]  last_exp;
  logic [CRC_W-1:0]  trace[11];
  int                n_checks;
  int                n_pass;

  // Reference: polynomial long division of data*x^5 by 100101.
  function automatic logic [CRC_W-1:0] crc_ref(input logic [DATA_W-1:0] d);
    logic [DATA_W+CRC_W-1:0] r;
    r = {d, {CRC_W{1'b0}}};
    for (int i = DATA_W + CRC_W - 1; i >= CRC_W; i--) begin
      if (r[i]) r[i -: 6] = r[i -: 6] ^ 6'b100101;
    end
    return r[CRC_W-1:0];
  endfunction

  task automatic check(input string name, input logic [CRC_W-1:0] act,
                       input logic [CRC_W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b, required %b", name, act, req);
  endtask

  task automatic pop_check(input string name);
    logic [CRC_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got %b", name, data_out);
    end else begin
      e = exp_q.pop_front();
      check(name, data_out, e);
      last_exp = e;
    end
  endtask

  // Called at a negedge with the next posedge being LOAD. Optionally changes
  // data_in to chg_val after chg_at SHIFT clocks (chg_at < 0: no change).
  task automatic run_word(input string name, input logic [DATA_W-1:0] d,
                          input logic [CRC_W-1:0] e, input int chg_at,
                          input logic [DATA_W-1:0] chg_val);
    data_in = d;
    exp_q.push_back(e);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k - 1 == chg_at) data_in = chg_val;
    end
    check({name, "_hold"}, data_out, last_exp);
    @(negedge clk);
    pop_check(name);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_exp = '0;
    vecs[0] = '{6'b111001, 5'b00011};
    vecs[1] = '{6'b101011, 5'b10011};
    vecs[2] = '{6'b000000, 5'b00000};
    vecs[3] = '{6'b100101, 5'b00000};
    vecs[4] = '{6'b111001, 5'b00011};
    vecs[5] = '{6'b111001, 5'b00011};
    trace = '{5'b00001, 5'b00011, 5'b00111, 5'b01110, 5'b11100, 5'b11100,
              5'b11101, 5'b11111, 5'b11011, 5'b10011, 5'b00011};

    // Reset held: output stays zero across clock edges.
    reset   = 1'b1;
    data_in = 6'b111001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_hold", data_out, 5'b00000);
    end
    reset = 1'b0;

    // LFSR trace for 111001 followed by the published result.
    exp_q.push_back(5'b00011);
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check($sformatf("trace_%0d", i), dut.r_lfsr, trace[i]);
    end
    check("first_hold", data_out, 5'b00000);
    @(negedge clk);
    pop_check("first_result");

    // Table-driven words, back to back.
    for (int i = 0; i < 6; i++)
      run_word($sformatf("vec_%0d", i), vecs[i].din, vecs[i].exp, -1, '0);

    // Post-message LFSR value for 101011.
    data_in = 6'b101011;
    exp_q.push_back(5'b10011);
    for (int k = 1; k <= 7; k++) @(negedge clk);
    check("post_msg_lfsr", dut.r_lfsr, 5'b01110);
    for (int k = 8; k <= 13; k++) @(negedge clk);
    pop_check("vec_101011b");

    // data_in changed mid-SHIFT: in-flight result unaffected.
    run_word("midchg", 6'b111001, 5'b00011, 3, 6'b101011);
    run_word("after_chg", 6'b101011, 5'b10011, -1, '0);

    // Random words against the division model.
    for (int i = 0; i < 4; i++) begin
      logic [DATA_W-1:0] r;
      r = DATA_W'($urandom_range(0, 63));
      run_word($sformatf("rand_%0d", i), r, crc_ref(r), -1, '0);
    end
    // Ensure a non-zero published value before the abort test.
    run_word("pre_abort", 6'b101011, 5'b10011, -1, '0);

    // Reset asserted between edges, 7 clocks into SHIFT.
    data_in = 6'b111001;
    for (int k = 1; k <= 8; k++) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", data_out, 5'b00000);
    @(negedge clk);
    check("abort_no_publish", data_out, 5'b00000);
    reset    = 1'b0;
    last_exp = '0;
    run_word("after_abort", 6'b111001, 5'b00011, -1, '0);
    run_word("after_abort2", 6'b100101, 5'b00000, -1, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_crc_eq2.md
Name: serial_crc_eq2

Overview:
- Bit-serial CRC-5 generator: captures a 6-bit message word and divides it, MSB first, one bit per clock, by G(x) = x^5 + x^2 + 1 through a 5-bit LFSR.
- The LFSR is in augmented (long-division) form: 5 zero bits are appended after the message.
- Presents the 5-bit remainder on data_out.
- Runs continuously: re-captures data_in and recomputes after every result.
- Sits beside a framing/transmit path as the checksum source for short message words.

Parameters:
- DATA_W, 6, message width in bits.
- CRC_W, 5, CRC/remainder width.
- POLY, 5'b00101, generator coefficients x^4..x^0; the x^CRC_W term is implicit.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- data_in  input  DATA_W  message word; sampled only in LOAD.
- data_out  output  CRC_W  registered CRC remainder of the last completed message.

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - reset is asynchronous and active-high.
  - While reset is high: data_out=0, lfsr=0, msg=0, bit counter=0, state=LOAD.
- State machine: LOAD -> SHIFT -> DONE -> LOAD.
- LOAD, one clock:
  - msg <= data_in; lfsr <= 0; cnt <= 0; go to SHIFT.
- SHIFT, DATA_W+CRC_W = 11 clocks:
  - Input bit b = msg[DATA_W-1] while cnt < DATA_W, else 0 (augmenting zeros).
  - msg shifts left by one each clock.
  - lfsr <= {lfsr[3:0], b} XOR (lfsr[4] ? POLY : 0).
  - cnt increments each clock; leave SHIFT after the clock with cnt = 10.
- DONE, one clock:
  - data_out <= lfsr; go to LOAD.
- Timing:
  - Period is 13 clocks per result.
  - First data_out update occurs on the 13th rising edge after reset deasserts.
  - data_out holds its value between updates.
- Input sampling:
  - data_in changes outside LOAD have no effect on the computation in flight.
  - With data_in constant, data_out is constant after the first result.
- data_out must equal (data_in · x^5) mod G(x) over GF(2) for the captured word.
- Reset mid-computation:
  - Aborts the computation immediately.
  - data_out returns to 0.
  - The sequence restarts from LOAD after reset release; no partial result is ever published.
- All arithmetic is GF(2) XOR; no carries. Widths are exactly CRC_W for the LFSR and DATA_W for msg.
- cnt must be wide enough for DATA_W+CRC_W-1 (4 bits at defaults) and must not wrap within SHIFT.

Test Plan:
- Reset check: hold reset, toggle clk 5 cycles -> data_out = 5'b00000 throughout.
- Asynchronous assertion: assert reset between edges -> data_out = 0 immediately, with no clock edge.
- data_in=6'b111001:
  - Release reset and wait 13 edges -> data_out = 5'b00011.
  - Expected LFSR trace after each shift: 00001, 00011, 00111, 01110, 11100, 11100, 11101, 11111, 11011, 10011, 00011.
  - Value stays 00011 across subsequent 13-cycle periods.
- data_in=6'b101011 -> data_out = 5'b10011 after 13 edges; post-message LFSR = 01110.
- Zero and polynomial words:
  - data_in=6'b000000 -> data_out = 5'b00000.
  - data_in=6'b100101 (the generator itself) -> data_out = 5'b00000.
- Input sampling and mid-run reset:
  - Change data_in from 111001 to 101011 during SHIFT -> current result still 00011; next period yields 10011.
  - Assert reset at cycle 7 of SHIFT -> data_out=0; after release, the full 13-cycle sequence repeats and produces the correct CRC.
